// File: rtl/reg16_serializer_if.sv
// Load-side and serial-side handshake bundle for reg16_serializer.
// The master modport belongs to the producer/consumer pair; the serializer takes the slave modport.
interface reg16_serializer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             ld_valid;
  logic             ld_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             busy;
  logic             done;

  modport master (
    output in, ld_valid, sout_ready,
    input  ld_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  in, ld_valid, sout_ready,
    output ld_ready, sout, sout_valid, busy, done
  );
endinterface

// File: rtl/reg16_serializer.sv
// Parallel-to-serial unloader: captures a word on ld_valid/ld_ready, then emits one bit per sout handshake.
// Optional feature: define SER_PARITY_EN to append an even-parity bit after the data bits.
module reg16_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  reg16_serializer_if.slave bus
);

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             sout_q;
  logic             sout_valid_q;
  logic             busy_q;
  logic             done_q;
`ifdef SER_PARITY_EN
  logic             parity_q;
`endif

  logic [WIDTH-1:0] shifted;
  logic             load_bit;
  logic             next_bit;
  logic             load_fire;
  logic             bit_fire;
  logic             last_bit;

  // Ready depends on state alone so the producer can never form a combinational loop through it.
  assign bus.ld_ready   = (state == IDLE);
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  assign load_fire = (state == IDLE) && bus.ld_valid;
  assign bit_fire  = (state == SHIFT) && sout_valid_q && bus.sout_ready;
  assign last_bit  = (count == LAST_IDX);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shifted  = '0;
    load_bit = 1'b0;
    next_bit = 1'b0;
    if (MSB_FIRST) begin
      shifted  = {shreg[WIDTH-2:0], 1'b0};
      load_bit = bus.in[WIDTH-1];
      next_bit = shifted[WIDTH-1];
    end else begin
      shifted  = {1'b0, shreg[WIDTH-1:1]};
      load_bit = bus.in[0];
      next_bit = shifted[0];
    end
`ifdef SER_PARITY_EN
    // The bit after the last data bit is the parity captured at load time.
    if (count == CW'(WIDTH - 1)) next_bit = parity_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state        <= IDLE;
      shreg        <= '0;
      count        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load_fire) begin
            shreg        <= bus.in;
            count        <= '0;
            state        <= SHIFT;
            sout_q       <= load_bit;
            sout_valid_q <= 1'b1;
            busy_q       <= 1'b1;
`ifdef SER_PARITY_EN
            parity_q     <= ^bus.in;
`endif
          end
        end
        SHIFT: begin
          if (bit_fire) begin
            // Count saturates at NBITS on the final bit and is cleared only by the next load.
            count <= count + 1'b1;
            if (last_bit) begin
              state        <= IDLE;
              sout_q       <= 1'b0;
              sout_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              shreg  <= shifted;
              sout_q <= next_bit;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg16_serializer.sv
// Directed self-checking bench for reg16_serializer (MSB first); define SER_PARITY_EN to also cover parity.
module tb_reg16_serializer;
  localparam int WIDTH = 16;
`ifdef SER_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg16_serializer_if #(.WIDTH(WIDTH)) bus ();

  reg16_serializer #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic load_word(input logic [15:0] word);
    bus.in       = word;
    bus.ld_valid = 1'b1;
    step();
    bus.ld_valid = 1'b0;
    bus.in       = ~word;
  endtask

  // Full-rate unload: expects NBITS bits back to back, then one done cycle.
  task automatic shift_full(input logic [15:0] word, input logic par, input string tag);
    logic [16:0] seq;
    seq = {word, par};
    bus.sout_ready = 1'b1;
    for (int k = 0; k < NBITS; k++) begin
      check($sformatf("%s_valid%0d", tag, k), bus.sout_valid, 1'b1);
      check($sformatf("%s_bit%0d", tag, k), bus.sout, seq[16-k]);
      check($sformatf("%s_ldrdy%0d", tag, k), bus.ld_ready, 1'b0);
      check($sformatf("%s_busy%0d", tag, k), bus.busy, 1'b1);
      check($sformatf("%s_nodone%0d", tag, k), bus.done, 1'b0);
      step();
    end
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_end_valid"}, bus.sout_valid, 1'b0);
    check({tag, "_end_sout"}, bus.sout, 1'b0);
    check({tag, "_end_busy"}, bus.busy, 1'b0);
    check({tag, "_end_ldrdy"}, bus.ld_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] pat;
    logic [15:0] bp_word;
    int          sent;
    int          cyc;

    rst_n          = 1'b0;
    bus.in         = '0;
    bus.ld_valid   = 1'b0;
    bus.sout_ready = 1'b0;

    // 1: reset held for two cycles
    step();
    step();
    check("rst_ldrdy", bus.ld_ready, 1'b1);
    check("rst_valid", bus.sout_valid, 1'b0);
    check("rst_sout", bus.sout, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    rst_n = 1'b1;
    step();
    check("post_rst_ldrdy", bus.ld_ready, 1'b1);
    check("post_rst_valid", bus.sout_valid, 1'b0);

    // 2: A5C3 -> 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 at full rate (even parity 0)
    load_word(16'hA5C3);
    shift_full(16'hA5C3, 1'b0, "a5c3");

    // 3: back-to-back load in the done cycle, then 8001 under back-pressure
    load_word(16'h8001);
    bp_word = 16'h8001;
    pat     = 32'hB4D2_6A39;
    sent    = 0;
    cyc     = 0;
    while (sent < NBITS && cyc < 200) begin
      bus.sout_ready = pat[cyc % 32];
      check($sformatf("bp_valid_c%0d", cyc), bus.sout_valid, 1'b1);
      check($sformatf("bp_bit%0d_c%0d", sent, cyc), bus.sout,
            (sent < 16) ? bp_word[15-sent] : 1'b0);
      check($sformatf("bp_nodone_c%0d", cyc), bus.done, 1'b0);
      step();
      if (bus.sout_ready) sent++;
      cyc++;
    end
    check("bp_bits_sent", sent, NBITS);
    check("bp_done", bus.done, 1'b1);
    check("bp_end_valid", bus.sout_valid, 1'b0);
    bus.sout_ready = 1'b1;
    step();
    check("bp_done_once", bus.done, 1'b0);
    check("bp_idle_valid", bus.sout_valid, 1'b0);

    // 4: ld_valid with FFFF during the shift of 0000 is ignored
    load_word(16'h0000);
    bus.in       = 16'hFFFF;
    bus.ld_valid = 1'b1;
    shift_full(16'h0000, 1'b0, "ign");
    bus.ld_valid = 1'b0;
    step();
    check("ign_no_reload", bus.sout_valid, 1'b0);
    check("ign_idle_busy", bus.busy, 1'b0);

    // 5: reset after 5 bits of 1234 aborts the word
    load_word(16'h1234);
    bus.sout_ready = 1'b1;
    repeat (5) step();
    check("abort_bit5", bus.sout, 1'b0);
    check("abort_busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    step();
    check("abort_ldrdy", bus.ld_ready, 1'b1);
    check("abort_valid", bus.sout_valid, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    rst_n = 1'b1;
    step();
    check("abort_no_done", bus.done, 1'b0);
    check("abort_idle_valid", bus.sout_valid, 1'b0);
    load_word(16'h00FF);
    shift_full(16'h00FF, 1'b0, "x00ff");

`ifdef SER_PARITY_EN
    // 6: parity bit after the data bits
    load_word(16'h0007);
    shift_full(16'h0007, 1'b1, "par7");
    load_word(16'h0003);
    shift_full(16'h0003, 1'b0, "par3");
`endif

    step();
    check("final_done_clear", bus.done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
